alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-byte command sequencer for the 8-bit ALU. It accepts one NBYTES-wide arithmetic/logic command over a valid/ready handshake.
- It drives the ALU one byte at a time, least-significant first, using the carry-chained opcode for upper bytes. It collects the bus results and returns one wide result plus aggregated flags.
- It sits between the microcode/control unit and the alu instance and owns the ALU operation, operand and assert_bus inputs while busy.

Parameters:
- WIDTH, 8, ALU datapath width in bits.
- NBYTES, 2, number of ALU-width slices per command; legal range 1..8.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when req_valid and req_ready
- req_cmd  in  2  0=ADD, 1=SUB, 2=AND, 3=OR
- req_lhs  in  WIDTH*NBYTES  left operand
- req_rhs  in  WIDTH*NBYTES  right operand
- resp_valid  out  1  result valid
- resp_ready  in  1  result consumed when resp_valid and resp_ready
- resp_result  out  WIDTH*NBYTES  assembled result
- resp_zero  out  1  whole result is zero
- resp_carry  out  1  carry/borrow out of top slice
- resp_sign  out  1  MSB of top slice
- resp_overflow  out  1  signed overflow of top slice
- resp_err  out  1  ALU failed to drive the bus in some slice
- busy  out  1  high in every state except IDLE
- alu_operation  out  4  ALU opcode
- alu_lhs  out  WIDTH  slice operand
- alu_rhs  out  WIDTH  slice operand
- alu_assert_bus  out  1  ALU bus drive request
- alu_bus_out  in  WIDTH  ALU result
- alu_bus_en  in  1  ALU bus driving
- alu_flag_zero  in  1  ALU flag
- alu_flag_acarry  in  1  ALU flag
- alu_flag_sign  in  1  ALU flag
- alu_flag_overflow  in  1  ALU flag

Behaviour:
- Reset, asynchronous on rst_n low:
  - State goes to IDLE.
  - alu_operation=0 (NOP), alu_assert_bus=0, alu_lhs/alu_rhs=0.
  - resp_valid=0, resp_result=0, all resp flags=0, resp_err=0, busy=0.
  - req_ready=1 after reset.
  - Reset mid-command aborts it with no response; the ALU's internal carry is not cleared by this block.
- FSM states: IDLE, OP, GAP, DONE.
- IDLE:
  - req_ready=1.
  - On handshake, latch operands and cmd, set slice index i=0, clear the zero accumulator and err, then go to OP.
- OP, exactly 1 cycle:
  - alu_operation set by slice and cmd:
    - Slice 0: ADD=4'h3, SUB=4'h7, AND=4'hA, OR=4'hB.
    - Slice i>0: ADD->ADDC 4'h4, SUB->SUBB 4'h8; AND/OR unchanged.
  - alu_lhs/alu_rhs = slice i of the latched operands; alu_assert_bus=1.
  - Sample alu_bus_out into result slice i at the clock edge.
  - If alu_bus_en=0 in this cycle, set the sticky err and write 0 into slice i.
  - Go to GAP.
- GAP, exactly 1 cycle:
  - alu_operation=0, alu_assert_bus=0.
  - ALU flags now hold the registered values of slice i; accumulate zero &= alu_flag_zero.
  - If i==NBYTES-1: capture carry/sign/overflow from the ALU, go to DONE.
  - Otherwise i++ and go to OP.
- DONE:
  - resp_valid=1; resp_* outputs stable.
  - On resp_ready, go to IDLE.
  - resp_* outputs hold their last values until the next DONE.
- req_ready is 0 in OP, GAP and DONE. There is no request/response overlap: the next command is accepted no earlier than the cycle after the response handshake.
- Latency: request handshake to resp_valid = 2*NBYTES cycles.
- resp_zero reflects ALU flags, not a recomputation. For AND/OR, resp_carry and resp_overflow pass through whatever the ALU reports.
- Operand inputs may change freely after acceptance; only the latched copies are used.

Decomposition:
- Package alu_pkg:
  - ALU opcode localparams: NOP=4'h0, ADD=4'h3, ADDC=4'h4, SUB=4'h7, SUBB=4'h8, AND=4'hA, OR=4'hB.
  - req_cmd encoding and the FSM state enum.
- No sub-module: the slice mux and opcode select stay inline.
- The bench needs a behavioural ALU model with registered flags and a carry latch; it is bench-only, not RTL.

Test Plan:
- ADD 0x12FF+0x0001 -> opcode sequence 3,0,4,0; resp_result=0x1300, zero=0, carry=0; resp_valid exactly 4 cycles after the handshake.
- ADD 0xFFFF+0x0001 -> result=0x0000, zero=1, carry=1; AND 0x5555&0xAAAA -> opcodes A,0,A,0, result=0x0000, zero=1.
- SUB 0x0100-0x0001 -> opcodes 7,0,8,0, result=0x00FF, zero=0, borrow=0; SUB 0x0001-0x0081 -> 0xFF80, sign=1.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and result stay stable, req_ready=0, a new req_valid is ignored; it is accepted the cycle after resp_ready=1.
- Model drops alu_bus_en during the slice-1 OP -> resp_err=1, result[15:8]=0, other slices correct; err clears on the next command.
- Assert rst_n=0 during the first GAP -> all outputs return to their reset values immediately, no resp_valid; a fresh OR 0x0F0F|0x00F0 afterwards returns 0x0FFF.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-byte ALU sequencer:
//   - 8-bit ALU opcode constants driven onto alu_operation
//   - command encoding carried on req_cmd
//   - FSM state encoding of the sequencer
//   - helper that maps a command plus slice position onto an ALU opcode
// -----------------------------------------------------------------------------
package alu_pkg;

  // ALU opcodes understood by the 8-bit ALU
  localparam logic [3:0] ALU_NOP  = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h3;
  localparam logic [3:0] ALU_ADDC = 4'h4;
  localparam logic [3:0] ALU_SUB  = 4'h7;
  localparam logic [3:0] ALU_SUBB = 4'h8;
  localparam logic [3:0] ALU_AND  = 4'hA;
  localparam logic [3:0] ALU_OR   = 4'hB;

  // Command encoding on req_cmd
  typedef enum logic [1:0] {
    CMD_ADD = 2'd0,
    CMD_SUB = 2'd1,
    CMD_AND = 2'd2,
    CMD_OR  = 2'd3
  } cmd_e;

  // Sequencer states: OP drives one slice, GAP lets the ALU flags settle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // The lowest slice starts a fresh carry chain; upper slices of ADD/SUB
  // must consume the carry/borrow the ALU latched from the slice below.
  function automatic logic [3:0] slice_opcode(input cmd_e cmd, input logic first_slice);
    logic [3:0] op;
    op = ALU_NOP;
    case (cmd)
      CMD_ADD: op = first_slice ? ALU_ADD : ALU_ADDC;
      CMD_SUB: op = first_slice ? ALU_SUB : ALU_SUBB;
      CMD_AND: op = ALU_AND;
      CMD_OR:  op = ALU_OR;
      default: op = ALU_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
// Runs one NBYTES*WIDTH-bit ADD/SUB/AND/OR command through an 8-bit ALU one
// slice at a time (least significant first) and returns the assembled result
// with aggregated flags.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req_valid/req_ready        command handshake
//   req_cmd, req_lhs, req_rhs  command and wide operands (latched on accept)
//   resp_valid/resp_ready      response handshake
//   resp_result                assembled wide result
//   resp_zero/carry/sign/overflow  flags aggregated from the ALU
//   resp_err                   ALU did not drive the bus in some slice
//   busy                       high whenever not IDLE
//   alu_operation, alu_lhs, alu_rhs, alu_assert_bus   drive the ALU
//   alu_bus_out, alu_bus_en, alu_flag_*               returned by the ALU
// -----------------------------------------------------------------------------
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NBYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_cmd,
  input  logic [WIDTH*NBYTES-1:0]  req_lhs,
  input  logic [WIDTH*NBYTES-1:0]  req_rhs,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH*NBYTES-1:0]  resp_result,
  output logic                     resp_zero,
  output logic                     resp_carry,
  output logic                     resp_sign,
  output logic                     resp_overflow,
  output logic                     resp_err,
  output logic                     busy,
  output logic [3:0]               alu_operation,
  output logic [WIDTH-1:0]         alu_lhs,
  output logic [WIDTH-1:0]         alu_rhs,
  output logic                     alu_assert_bus,
  input  logic [WIDTH-1:0]         alu_bus_out,
  input  logic                     alu_bus_en,
  input  logic                     alu_flag_zero,
  input  logic                     alu_flag_acarry,
  input  logic                     alu_flag_sign,
  input  logic                     alu_flag_overflow
);

  localparam int TOTAL = WIDTH * NBYTES;
  localparam int IDXW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q;
  cmd_e              cmd_q;
  logic [WIDTH-1:0]  lhs_q [NBYTES];
  logic [WIDTH-1:0]  rhs_q [NBYTES];
  logic [WIDTH-1:0]  res_q [NBYTES];
  logic [TOTAL-1:0]  res_packed;
  logic              zero_acc_q;
  logic              err_acc_q;
  logic              req_fire;
  logic              is_last;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign req_fire   = req_valid && req_ready;
  assign is_last    = (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and ALU drive; the ALU only sees a real opcode during OP
  always_comb begin
    state_d        = state_q;
    alu_operation  = ALU_NOP;
    alu_assert_bus = 1'b0;
    alu_lhs        = '0;
    alu_rhs        = '0;
    case (state_q)
      IDLE: begin
        if (req_fire) state_d = OP;
      end
      OP: begin
        alu_operation  = slice_opcode(cmd_q, idx_q == '0);
        alu_lhs        = lhs_q[idx_q];
        alu_rhs        = rhs_q[idx_q];
        alu_assert_bus = 1'b1;
        state_d        = GAP;
      end
      GAP: begin
        state_d = is_last ? DONE : OP;
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flatten the collected slices for the final response copy
  always_comb begin
    res_packed = '0;
    for (int b = 0; b < NBYTES; b++) begin
      res_packed[b*WIDTH +: WIDTH] = res_q[b];
    end
  end

  // Datapath: operand latch, slice collection and flag aggregation.
  // The working accumulators are separate from resp_* so a newly accepted
  // command cannot disturb the previous response before its own DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q         <= '0;
      cmd_q         <= CMD_ADD;
      zero_acc_q    <= 1'b1;
      err_acc_q     <= 1'b0;
      resp_result   <= '0;
      resp_zero     <= 1'b0;
      resp_carry    <= 1'b0;
      resp_sign     <= 1'b0;
      resp_overflow <= 1'b0;
      resp_err      <= 1'b0;
      for (int b = 0; b < NBYTES; b++) begin
        lhs_q[b] <= '0;
        rhs_q[b] <= '0;
        res_q[b] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            cmd_q      <= cmd_e'(req_cmd);
            idx_q      <= '0;
            zero_acc_q <= 1'b1;
            err_acc_q  <= 1'b0;
            for (int b = 0; b < NBYTES; b++) begin
              lhs_q[b] <= req_lhs[b*WIDTH +: WIDTH];
              rhs_q[b] <= req_rhs[b*WIDTH +: WIDTH];
            end
          end
        end
        OP: begin
          if (alu_bus_en) begin
            res_q[idx_q] <= alu_bus_out;
          end else begin
            res_q[idx_q] <= '0;
            err_acc_q    <= 1'b1;
          end
        end
        GAP: begin
          // ALU flags registered at the end of OP now describe slice idx_q
          zero_acc_q <= zero_acc_q & alu_flag_zero;
          if (is_last) begin
            resp_result   <= res_packed;
            resp_zero     <= zero_acc_q & alu_flag_zero;
            resp_carry    <= alu_flag_acarry;
            resp_sign     <= alu_flag_sign;
            resp_overflow <= alu_flag_overflow;
            resp_err      <= err_acc_q;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. A behavioural 8-bit ALU with
// registered flags and a carry latch answers the sequencer; expected wide
// results come from an independent full-width reference and are queued on
// acceptance, then popped when the response is consumed.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int NB = 2;
  localparam int TW = W * NB;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_cmd;
  logic [TW-1:0] req_lhs;
  logic [TW-1:0] req_rhs;
  logic          resp_valid;
  logic          resp_ready;
  logic [TW-1:0] resp_result;
  logic          resp_zero;
  logic          resp_carry;
  logic          resp_sign;
  logic          resp_overflow;
  logic          resp_err;
  logic          busy;
  logic [3:0]    alu_operation;
  logic [W-1:0]  alu_lhs;
  logic [W-1:0]  alu_rhs;
  logic          alu_assert_bus;
  logic [W-1:0]  alu_bus_out;
  logic          alu_bus_en;
  logic          alu_flag_zero;
  logic          alu_flag_acarry;
  logic          alu_flag_sign;
  logic          alu_flag_overflow;

  logic          drop_bus;
  int            err_count;
  int            check_count;

  typedef struct {
    logic [TW-1:0] result;
    logic          zero;
    logic          carry;
    logic          sign;
    logic          ovf;
    logic          err;
  } resp_t;

  resp_t sb_q[$];

  alu_sequencer #(.WIDTH(W), .NBYTES(NB)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_cmd           (req_cmd),
    .req_lhs           (req_lhs),
    .req_rhs           (req_rhs),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_result       (resp_result),
    .resp_zero         (resp_zero),
    .resp_carry        (resp_carry),
    .resp_sign         (resp_sign),
    .resp_overflow     (resp_overflow),
    .resp_err          (resp_err),
    .busy              (busy),
    .alu_operation     (alu_operation),
    .alu_lhs           (alu_lhs),
    .alu_rhs           (alu_rhs),
    .alu_assert_bus    (alu_assert_bus),
    .alu_bus_out       (alu_bus_out),
    .alu_bus_en        (alu_bus_en),
    .alu_flag_zero     (alu_flag_zero),
    .alu_flag_acarry   (alu_flag_acarry),
    .alu_flag_sign     (alu_flag_sign),
    .alu_flag_overflow (alu_flag_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: combinational bus result, flags and carry registered
  logic [W:0] alu_tmp;
  logic       alu_v;
  logic       alu_arith;
  logic       carry_latch;

  always_comb begin
    alu_tmp   = '0;
    alu_v     = 1'b0;
    alu_arith = 1'b0;
    case (alu_operation)
      4'h3: begin
        alu_tmp = {1'b0, alu_lhs} + {1'b0, alu_rhs};
        alu_arith = 1'b1;
      end
      4'h4: begin
        alu_tmp = {1'b0, alu_lhs} + {1'b0, alu_rhs} + (W+1)'(carry_latch);
        alu_arith = 1'b1;
      end
      4'h7: begin
        alu_tmp = {1'b0, alu_lhs} - {1'b0, alu_rhs};
        alu_arith = 1'b1;
      end
      4'h8: begin
        alu_tmp = {1'b0, alu_lhs} - {1'b0, alu_rhs} - (W+1)'(carry_latch);
        alu_arith = 1'b1;
      end
      4'hA: alu_tmp = {1'b0, alu_lhs & alu_rhs};
      4'hB: alu_tmp = {1'b0, alu_lhs | alu_rhs};
      default: alu_tmp = '0;
    endcase
    if (alu_operation == 4'h3 || alu_operation == 4'h4)
      alu_v = (alu_lhs[W-1] == alu_rhs[W-1]) && (alu_tmp[W-1] != alu_lhs[W-1]);
    else if (alu_operation == 4'h7 || alu_operation == 4'h8)
      alu_v = (alu_lhs[W-1] != alu_rhs[W-1]) && (alu_tmp[W-1] != alu_lhs[W-1]);
  end

  assign alu_bus_out = alu_tmp[W-1:0];
  assign alu_bus_en  = alu_assert_bus && !drop_bus;

  initial begin
    carry_latch       = 1'b0;
    alu_flag_zero     = 1'b0;
    alu_flag_acarry   = 1'b0;
    alu_flag_sign     = 1'b0;
    alu_flag_overflow = 1'b0;
  end

  always @(posedge clk) begin
    if (alu_operation != 4'h0) begin
      alu_flag_zero     <= (alu_tmp[W-1:0] == '0);
      alu_flag_acarry   <= alu_arith ? alu_tmp[W] : 1'b0;
      alu_flag_sign     <= alu_tmp[W-1];
      alu_flag_overflow <= alu_v;
      if (alu_arith) carry_latch <= alu_tmp[W];
    end
  end

  // Full-width reference of one command, independent of slicing
  function automatic resp_t ref_calc(input cmd_e cmd, input logic [TW-1:0] l,
                                     input logic [TW-1:0] r, input int drop_slice);
    logic [TW:0] t;
    resp_t e;
    t = '0;
    case (cmd)
      CMD_ADD: t = {1'b0, l} + {1'b0, r};
      CMD_SUB: t = {1'b0, l} - {1'b0, r};
      CMD_AND: t = {1'b0, l & r};
      default: t = {1'b0, l | r};
    endcase
    e.result = t[TW-1:0];
    e.zero   = (t[TW-1:0] == '0);
    e.sign   = t[TW-1];
    e.carry  = (cmd == CMD_ADD || cmd == CMD_SUB) ? t[TW] : 1'b0;
    if (cmd == CMD_ADD)
      e.ovf = (l[TW-1] == r[TW-1]) && (t[TW-1] != l[TW-1]);
    else if (cmd == CMD_SUB)
      e.ovf = (l[TW-1] != r[TW-1]) && (t[TW-1] != l[TW-1]);
    else
      e.ovf = 1'b0;
    e.err = 1'b0;
    if (drop_slice >= 0) begin
      e.err = 1'b1;
      e.result[drop_slice*W +: W] = '0;
    end
    return e;
  endfunction

  function automatic logic [3:0] exp_opcode(input cmd_e cmd, input int slice);
    case (cmd)
      CMD_ADD: return (slice == 0) ? 4'h3 : 4'h4;
      CMD_SUB: return (slice == 0) ? 4'h7 : 4'h8;
      CMD_AND: return 4'hA;
      default: return 4'hB;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Drive one command, follow its slice sequence and optionally drop the
  // bus in one slice or abort it with reset at a given cycle.
  task automatic applyStimulus(input cmd_e cmd, input logic [TW-1:0] l,
                               input logic [TW-1:0] r, input int drop_slice,
                               input int abort_cycle);
    resp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_lhs   = l;
    req_rhs   = r;
    checkOutput("req_ready_idle", req_ready, 1);
    checkOutput("busy_idle", busy, 0);
    @(posedge clk);
    #1;
    e = ref_calc(cmd, l, r, drop_slice);
    sb_q.push_back(e);
    req_valid = 1'b0;
    req_cmd   = 2'($urandom);
    req_lhs   = TW'($urandom);
    req_rhs   = TW'($urandom);
    for (int k = 1; k <= 2*NB + 1; k++) begin
      @(negedge clk);
      if (k == abort_cycle) begin
        rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_resp_valid", resp_valid, 0);
        checkOutput("abort_req_ready", req_ready, 1);
        checkOutput("abort_alu_op", alu_operation, 0);
        checkOutput("abort_assert_bus", alu_assert_bus, 0);
        checkOutput("abort_resp_result", resp_result, 0);
        void'(sb_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      drop_bus = (k % 2 == 1) && (k < 2*NB + 1) && (((k - 1) / 2) == drop_slice);
      if ((k % 2 == 1) && (k < 2*NB + 1)) begin
        checkOutput("opcode", alu_operation, exp_opcode(cmd, (k - 1) / 2));
        checkOutput("alu_lhs", alu_lhs, l[((k - 1) / 2)*W +: W]);
        checkOutput("alu_rhs", alu_rhs, r[((k - 1) / 2)*W +: W]);
      end else begin
        checkOutput("opcode_gap", alu_operation, 0);
      end
      checkOutput("resp_valid_timing", resp_valid, (k == 2*NB + 1));
    end
    drop_bus = 1'b0;
  endtask

  // Hold off the response for some cycles, then consume and compare it
  task automatic collectResponse(input int hold);
    resp_t e;
    if (sb_q.size() == 0) begin
      err_count++;
      check_count++;
      $display("[TB] FAIL scoreboard: actual=empty expected=entry");
      return;
    end
    e = sb_q[0];
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput("hold_resp_valid", resp_valid, 1);
      checkOutput("hold_result", resp_result, e.result);
      checkOutput("hold_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    checkOutput("resp_valid", resp_valid, 1);
    checkOutput("resp_result", resp_result, e.result);
    checkOutput("resp_zero", resp_zero, e.zero);
    checkOutput("resp_carry", resp_carry, e.carry);
    checkOutput("resp_sign", resp_sign, e.sign);
    checkOutput("resp_overflow", resp_overflow, e.ovf);
    checkOutput("resp_err", resp_err, e.err);
    void'(sb_q.pop_front());
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cmd_e rc;
    err_count   = 0;
    check_count = 0;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_cmd     = '0;
    req_lhs     = '0;
    req_rhs     = '0;
    resp_ready  = 1'b0;
    drop_bus    = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_alu_op", alu_operation, 0);
    checkOutput("rst_assert_bus", alu_assert_bus, 0);
    checkOutput("rst_alu_lhs", alu_lhs, 0);
    checkOutput("rst_resp_result", resp_result, 0);
    checkOutput("rst_resp_err", resp_err, 0);
    rst_n = 1'b1;

    applyStimulus(CMD_ADD, 16'h12FF, 16'h0001, -1, 0);
    collectResponse(0);
    applyStimulus(CMD_ADD, 16'hFFFF, 16'h0001, -1, 0);
    collectResponse(0);
    applyStimulus(CMD_AND, 16'h5555, 16'hAAAA, -1, 0);
    collectResponse(0);
    applyStimulus(CMD_SUB, 16'h0100, 16'h0001, -1, 0);
    collectResponse(0);
    applyStimulus(CMD_SUB, 16'h0001, 16'h0081, -1, 0);
    collectResponse(0);

    // Backpressure with a competing request held during DONE
    applyStimulus(CMD_ADD, 16'h1111, 16'h2222, -1, 0);
    req_valid = 1'b1;
    req_cmd   = CMD_OR;
    req_lhs   = 16'h0F00;
    req_rhs   = 16'h00F0;
    collectResponse(5);
    applyStimulus(CMD_OR, 16'h0F00, 16'h00F0, -1, 0);
    collectResponse(0);

    // Bus not driven in slice 1, then a clean command clears err
    applyStimulus(CMD_ADD, 16'h1234, 16'h0101, 1, 0);
    collectResponse(0);
    applyStimulus(CMD_SUB, 16'h5000, 16'h1000, -1, 0);
    collectResponse(0);

    // Reset during the first GAP aborts without a response
    applyStimulus(CMD_ADD, 16'h00FF, 16'h0001, -1, 2);
    @(negedge clk);
    checkOutput("no_resp_after_abort", resp_valid, 0);
    applyStimulus(CMD_OR, 16'h0F0F, 16'h00F0, -1, 0);
    collectResponse(0);

    for (int n = 0; n < 8; n++) begin
      rc = cmd_e'($urandom_range(0, 3));
      applyStimulus(rc, TW'($urandom), TW'($urandom), -1, 0);
      collectResponse(int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
